// File: rtl/fb_write_sched.sv
// Frame-buffer port-A write scheduler: full-buffer clear, NES pixel
// writes and a lower-priority auxiliary writer sharing one write port.
module fb_write_sched #(
   parameter logic [5:0] CLEAR_INIT = 6'd0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [5:0]  color,
   input  logic [8:0]  cycle,
   input  logic [8:0]  scanline,
   input  logic        clear_req,
   input  logic [5:0]  clear_color,
   input  logic        aux_valid,
   input  logic [15:0] aux_addr,
   input  logic [5:0]  aux_data,
   output logic        aux_ready,
   output logic        fb_we,
   output logic [15:0] fb_addr,
   output logic [5:0]  fb_wdata,
   output logic        clearing,
   output logic        clear_done,
   output logic        frame_done
);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  cx_q, cx_d;
   logic [7:0]  cy_q, cy_d;
   logic [5:0]  fill_q, fill_d;
   logic [8:0]  sl_prev_q, sl_prev_d;
   logic [8:0]  cyc_prev_q, cyc_prev_d;
   logic        fb_we_q, fb_we_d;
   logic [15:0] fb_addr_q, fb_addr_d;
   logic [5:0]  fb_wdata_q, fb_wdata_d;
   logic        clear_done_q, clear_done_d;
   logic        frame_done_q, frame_done_d;

   logic pix_evt;
   logic aux_in_range;

   // A pixel is new whenever the dot position moved inside the visible area
   assign pix_evt = ((scanline != sl_prev_q) || (cycle != cyc_prev_q))
                    && (scanline < 9'd240) && !cycle[8];
   assign aux_in_range = aux_addr[15:8] < 8'd240;

   assign clearing   = (state_q == S_CLEAR);
   assign aux_ready  = (state_q == S_RUN) && !pix_evt && !clear_req;
   assign fb_we      = fb_we_q;
   assign fb_addr    = fb_addr_q;
   assign fb_wdata   = fb_wdata_q;
   assign clear_done = clear_done_q;
   assign frame_done = frame_done_q;

   always_comb begin
      state_d      = state_q;
      cx_d         = cx_q;
      cy_d         = cy_q;
      fill_d       = fill_q;
      sl_prev_d    = scanline;
      cyc_prev_d   = cycle;
      fb_we_d      = 1'b0;
      fb_addr_d    = fb_addr_q;
      fb_wdata_d   = fb_wdata_q;
      clear_done_d = 1'b0;
      frame_done_d = 1'b0;
      case (state_q)
         S_CLEAR: begin
            if (clear_req) begin
               cx_d   = 8'd0;
               cy_d   = 8'd0;
               fill_d = clear_color;
            end else begin
               fb_we_d    = 1'b1;
               fb_addr_d  = {cy_q, cx_q};
               fb_wdata_d = fill_q;
               cx_d       = cx_q + 8'd1;
               if (cx_q == 8'hFF) begin
                  if (cy_q == 8'd239) begin
                     cy_d         = 8'd0;
                     state_d      = S_RUN;
                     clear_done_d = 1'b1;
                  end else begin
                     cy_d = cy_q + 8'd1;
                  end
               end
            end
         end
         S_RUN: begin
            if (clear_req) begin
               state_d = S_CLEAR;
               cx_d    = 8'd0;
               cy_d    = 8'd0;
               fill_d  = clear_color;
            end else if (pix_evt) begin
               fb_we_d      = 1'b1;
               fb_addr_d    = {scanline[7:0], cycle[7:0]};
               fb_wdata_d   = color;
               frame_done_d = (scanline[7:0] == 8'd239)
                              && (cycle[7:0] == 8'hFF);
            end else if (aux_valid) begin
               // Off-screen aux requests are accepted but never written
               fb_we_d = aux_in_range;
               if (aux_in_range) begin
                  fb_addr_d  = aux_addr;
                  fb_wdata_d = aux_data;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_CLEAR;
         cx_q         <= 8'd0;
         cy_q         <= 8'd0;
         fill_q       <= CLEAR_INIT;
         sl_prev_q    <= 9'd0;
         cyc_prev_q   <= 9'd0;
         fb_we_q      <= 1'b0;
         fb_addr_q    <= 16'd0;
         fb_wdata_q   <= 6'd0;
         clear_done_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         fill_q       <= fill_d;
         sl_prev_q    <= sl_prev_d;
         cyc_prev_q   <= cyc_prev_d;
         fb_we_q      <= fb_we_d;
         fb_addr_q    <= fb_addr_d;
         fb_wdata_q   <= fb_wdata_d;
         clear_done_q <= clear_done_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_fb_write_sched.sv
// Self-checking bench for fb_write_sched: directed scenarios plus a
// randomized RUN phase checked against a behavioural write model.
module tb_fb_write_sched;

   logic        clk;
   logic        resetn;
   logic [5:0]  color;
   logic [8:0]  cycle;
   logic [8:0]  scanline;
   logic        clear_req;
   logic [5:0]  clear_color;
   logic        aux_valid;
   logic [15:0] aux_addr;
   logic [5:0]  aux_data;
   logic        aux_ready;
   logic        fb_we;
   logic [15:0] fb_addr;
   logic [5:0]  fb_wdata;
   logic        clearing;
   logic        clear_done;
   logic        frame_done;

   int n_cmp;
   int n_err;

   fb_write_sched #(.CLEAR_INIT(6'd0)) dut (
      .clk(clk), .resetn(resetn), .color(color), .cycle(cycle),
      .scanline(scanline), .clear_req(clear_req),
      .clear_color(clear_color), .aux_valid(aux_valid),
      .aux_addr(aux_addr), .aux_data(aux_data), .aux_ready(aux_ready),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
      .clearing(clearing), .clear_done(clear_done),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; color = 6'd0; cycle = 9'd7; scanline = 9'd5;
      clear_req = 1'b0; clear_color = 6'd0; aux_valid = 1'b1;
      aux_addr = 16'h0101; aux_data = 6'd1;
      repeat (3) tick();
      n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", fb_we); end
      n_cmp++; if (fb_addr !== 16'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0000", fb_addr); end
      n_cmp++; if (fb_wdata !== 6'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 00", fb_wdata); end
      n_cmp++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL rst_cdone: got %b want 0", clear_done); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_fdone: got %b want 0", frame_done); end
      n_cmp++; if (clearing !== 1'b1) begin n_err++; $display("FAIL rst_clearing: got %b want 1", clearing); end
      n_cmp++; if (aux_ready !== 1'b0) begin n_err++; $display("FAIL rst_aux_ready: got %b want 0", aux_ready); end
      resetn = 1'b1;
   endtask

   task automatic test_clear();
      int bad;
      int bad2;
      int done_cnt;
      bad = 0; bad2 = 0; done_cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (fb_we !== 1'b1 || fb_addr !== 16'(i) || fb_wdata !== 6'd0
             || clearing !== 1'b1 || clear_done !== 1'b0
             || aux_ready !== 1'b0) bad++;
         cycle = 9'(i % 341); scanline = 9'(i % 7);
         clear_color = 6'h2A;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL clear_init_seq: %0d bad cycles, want 0", bad); end
      clear_req = 1'b1; clear_color = 6'h0D;
      tick();
      clear_req = 1'b0; clear_color = 6'h33;
      n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL clear_abort_we: got %b want 0", fb_we); end
      n_cmp++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL clear_abort_done: got %b want 0", clear_done); end
      for (int i = 0; i < 61440; i++) begin
         tick();
         if (clear_done === 1'b1) done_cnt++;
         if (fb_we !== 1'b1 || fb_addr !== 16'(i) || fb_wdata !== 6'h0D
             || clearing !== (i != 61439) || clear_done !== (i == 61439)
             || frame_done !== 1'b0) bad2++;
         if (i < 61000) begin
            cycle = 9'(i % 341); scanline = 9'(i % 250);
         end else begin
            aux_valid = 1'b0; cycle = 9'd77; scanline = 9'd3;
         end
      end
      n_cmp++; if (bad2 !== 0) begin n_err++; $display("FAIL clear_restart_seq: %0d bad cycles, want 0", bad2); end
      tick();
      if (clear_done === 1'b1) done_cnt++;
      n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL clear_done_cnt: got %0d want 1", done_cnt); end
      n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL post_clear_we: got %b want 0", fb_we); end
      n_cmp++; if (clearing !== 1'b0) begin n_err++; $display("FAIL post_clear_clearing: got %b want 0", clearing); end
   endtask

   task automatic test_pixel();
      scanline = 9'd10; cycle = 9'd5; color = 6'h03;
      tick();
      cycle = 9'd6; color = 6'h21;
      #1;
      n_cmp++; if (aux_ready !== 1'b0) begin n_err++; $display("FAIL px_aux_ready: got %b want 0", aux_ready); end
      tick();
      color = 6'h11;
      n_cmp++; if (fb_we !== 1'b1) begin n_err++; $display("FAIL px_we: got %b want 1", fb_we); end
      n_cmp++; if (fb_addr !== 16'h0A06) begin n_err++; $display("FAIL px_addr: got %h want 0a06", fb_addr); end
      n_cmp++; if (fb_wdata !== 6'h21) begin n_err++; $display("FAIL px_wdata: got %h want 21", fb_wdata); end
      tick();
      n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL px_hold_we: got %b want 0", fb_we); end
      n_cmp++; if (fb_addr !== 16'h0A06 || fb_wdata !== 6'h21) begin n_err++; $display("FAIL px_hold_val: got %h/%h want 0a06/21", fb_addr, fb_wdata); end
   endtask

   task automatic test_boundary();
      int bad;
      bad = 0;
      scanline = 9'd240; cycle = 9'd7; tick(); if (fb_we !== 1'b0) bad++;
      cycle = 9'd8; tick(); if (fb_we !== 1'b0) bad++;
      scanline = 9'd100; cycle = 9'd256; tick(); if (fb_we !== 1'b0) bad++;
      cycle = 9'd300; tick(); if (fb_we !== 1'b0) bad++;
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bnd_offscreen: %0d writes want 0", bad); end
      scanline = 9'd239; cycle = 9'd254; color = 6'h01;
      tick();
      n_cmp++; if (fb_we !== 1'b1 || fb_addr !== 16'hEFFE || frame_done !== 1'b0) begin n_err++; $display("FAIL bnd_effe: got we=%b addr=%h fd=%b want 1/effe/0", fb_we, fb_addr, frame_done); end
      cycle = 9'd255; color = 6'h02;
      tick();
      n_cmp++; if (fb_we !== 1'b1 || fb_addr !== 16'hEFFF || fb_wdata !== 6'h02) begin n_err++; $display("FAIL bnd_efff: got we=%b addr=%h d=%h want 1/efff/02", fb_we, fb_addr, fb_wdata); end
      n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL bnd_frame_done: got %b want 1", frame_done); end
      tick();
      n_cmp++; if (frame_done !== 1'b0 || fb_we !== 1'b0) begin n_err++; $display("FAIL bnd_frame_pulse: got fd=%b we=%b want 0/0", frame_done, fb_we); end
      scanline = 9'd20;
      tick();
      n_cmp++; if (fb_we !== 1'b1 || fb_addr !== 16'h14FF) begin n_err++; $display("FAIL bnd_sl_only: got we=%b addr=%h want 1/14ff", fb_we, fb_addr); end
   endtask

   task automatic test_aux();
      aux_valid = 1'b1; aux_addr = 16'h1234; aux_data = 6'd5;
      cycle = 9'd100; color = 6'h30;
      #1;
      n_cmp++; if (aux_ready !== 1'b0) begin n_err++; $display("FAIL aux_blocked: got %b want 0", aux_ready); end
      tick();
      n_cmp++; if (fb_we !== 1'b1 || fb_addr !== 16'h1464 || fb_wdata !== 6'h30) begin n_err++; $display("FAIL aux_px_wins: got %b/%h/%h want 1/1464/30", fb_we, fb_addr, fb_wdata); end
      n_cmp++; if (aux_ready !== 1'b1) begin n_err++; $display("FAIL aux_ready_idle: got %b want 1", aux_ready); end
      tick();
      n_cmp++; if (fb_we !== 1'b1 || fb_addr !== 16'h1234 || fb_wdata !== 6'd5) begin n_err++; $display("FAIL aux_write: got %b/%h/%h want 1/1234/05", fb_we, fb_addr, fb_wdata); end
      aux_addr = 16'hF000; aux_data = 6'd9;
      #1;
      n_cmp++; if (aux_ready !== 1'b1) begin n_err++; $display("FAIL aux_oor_ready: got %b want 1", aux_ready); end
      tick();
      n_cmp++; if (fb_we !== 1'b0 || fb_addr !== 16'h1234 || fb_wdata !== 6'd5) begin n_err++; $display("FAIL aux_oor_drop: got %b/%h/%h want 0/1234/05", fb_we, fb_addr, fb_wdata); end
      aux_addr = 16'hEFFF; aux_data = 6'd7;
      tick();
      n_cmp++; if (fb_we !== 1'b1 || fb_addr !== 16'hEFFF || frame_done !== 1'b0) begin n_err++; $display("FAIL aux_no_frame: got we=%b addr=%h fd=%b want 1/efff/0", fb_we, fb_addr, frame_done); end
      aux_valid = 1'b0;
      tick();
      n_cmp++; if (fb_we !== 1'b0) begin n_err++; $display("FAIL aux_idle_we: got %b want 0", fb_we); end
   endtask

   task automatic test_random();
      int e_rdy, e_out, f_k, n_frame;
      logic [8:0] psl, pcy;
      logic [15:0] m_addr, f_addr;
      logic [5:0] m_data;
      logic evt, exp_we, exp_fd, f_we, f_exp_we;
      e_rdy = 0; e_out = 0; f_k = 0; n_frame = 0;
      f_addr = '0; f_we = 1'b0; f_exp_we = 1'b0;
      psl = scanline; pcy = cycle;
      m_addr = 16'hEFFF; m_data = 6'd7;
      for (int k = 0; k < 3000; k++) begin
         case ($urandom_range(0, 3))
            0: begin
               scanline = 9'($urandom_range(0, 261));
               cycle = 9'($urandom_range(0, 340));
            end
            1: begin
               scanline = 9'($urandom_range(236, 243));
               cycle = 9'($urandom_range(250, 259));
            end
            default: ;
         endcase
         color = 6'($urandom);
         aux_valid = 1'($urandom_range(0, 1));
         aux_addr = 16'($urandom);
         if ($urandom_range(0, 1) == 1) aux_addr[15:8] = 8'($urandom_range(230, 255));
         aux_data = 6'($urandom);
         #1;
         evt = (scanline != psl || cycle != pcy)
               && scanline < 9'd240 && cycle < 9'd256;
         if (aux_ready !== !evt) e_rdy++;
         exp_we = 1'b0; exp_fd = 1'b0;
         if (evt) begin
            exp_we = 1'b1;
            m_addr = 16'(32'(scanline) * 256 + 32'(cycle));
            m_data = color;
            exp_fd = (scanline == 9'd239 && cycle == 9'd255);
         end else if (aux_valid && (32'(aux_addr) / 256) < 240) begin
            exp_we = 1'b1; m_addr = aux_addr; m_data = aux_data;
         end
         if (exp_fd) n_frame++;
         psl = scanline; pcy = cycle;
         tick();
         if (fb_we !== exp_we || frame_done !== exp_fd || clear_done !== 1'b0
             || fb_addr !== m_addr || fb_wdata !== m_data) begin
            if (e_out == 0) begin
               f_k = k; f_addr = fb_addr; f_we = fb_we; f_exp_we = exp_we;
            end
            e_out++;
         end
      end
      n_cmp++; if (e_rdy !== 0) begin n_err++; $display("FAIL rand_ready: %0d bad cycles, want 0", e_rdy); end
      n_cmp++; if (e_out !== 0) begin n_err++; $display("FAIL rand_out: %0d bad cycles (first k=%0d got we=%b addr=%h want we=%b), want 0", e_out, f_k, f_we, f_addr, f_exp_we); end
      $display("random phase: %0d frame-end writes exercised", n_frame);
   endtask

   task automatic test_clear_from_run();
      scanline = 9'd50; cycle = 9'd10; aux_valid = 1'b0;
      tick();
      cycle = 9'd11; aux_valid = 1'b1; aux_addr = 16'h0202;
      clear_req = 1'b1; clear_color = 6'h2B;
      #1;
      n_cmp++; if (aux_ready !== 1'b0) begin n_err++; $display("FAIL clr_aux_ready: got %b want 0", aux_ready); end
      tick();
      clear_req = 1'b0; clear_color = 6'h00;
      n_cmp++; if (fb_we !== 1'b0 || clearing !== 1'b1) begin n_err++; $display("FAIL clr_beats_px: got we=%b clr=%b want 0/1", fb_we, clearing); end
      n_cmp++; if (fb_addr !== 16'h320A) begin n_err++; $display("FAIL clr_hold_addr: got %h want 320a", fb_addr); end
      tick();
      n_cmp++; if (fb_we !== 1'b1 || fb_addr !== 16'h0 || fb_wdata !== 6'h2B) begin n_err++; $display("FAIL clr_first: got %b/%h/%h want 1/0000/2b", fb_we, fb_addr, fb_wdata); end
      n_cmp++; if (aux_ready !== 1'b0) begin n_err++; $display("FAIL clr_aux_blocked: got %b want 0", aux_ready); end
      tick();
      tick();
      n_cmp++; if (fb_addr !== 16'h0002 || fb_wdata !== 6'h2B) begin n_err++; $display("FAIL clr_third: got %h/%h want 0002/2b", fb_addr, fb_wdata); end
   endtask

   task automatic test_reset_async();
      #2;
      resetn = 1'b0;
      #1;
      n_cmp++; if (fb_we !== 1'b0 || fb_addr !== 16'h0 || fb_wdata !== 6'h0) begin n_err++; $display("FAIL arst_out: got %b/%h/%h want 0/0000/00", fb_we, fb_addr, fb_wdata); end
      n_cmp++; if (clearing !== 1'b1 || aux_ready !== 1'b0) begin n_err++; $display("FAIL arst_state: got clr=%b rdy=%b want 1/0", clearing, aux_ready); end
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      n_cmp++; if (fb_we !== 1'b1 || fb_addr !== 16'h0 || fb_wdata !== 6'h0) begin n_err++; $display("FAIL arst_restart: got %b/%h/%h want 1/0000/00", fb_we, fb_addr, fb_wdata); end
      tick();
      n_cmp++; if (fb_addr !== 16'h0001) begin n_err++; $display("FAIL arst_second: got %h want 0001", fb_addr); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_clear();
      test_pixel();
      test_boundary();
      test_aux();
      test_random();
      test_clear_from_run();
      test_reset_async();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
